// File: rtl/eth_tx_sched_if.sv
// Handshake and byte-stream bundle between the TX scheduler, the ARP/UDP sender
// engines and the PHY-facing TX port. The master modport is the scheduler side.
interface eth_tx_sched_if;
  logic       i_arp_resp_req;
  logic       i_arp_req_req;
  logic       i_udp_req;
  logic [1:0] o_arp_oper;
  logic       o_arp_enable;
  logic       i_arp_ready;
  logic [7:0] i_arp_data;
  logic       i_arp_tx_en;
  logic       o_udp_enable;
  logic       i_udp_ready;
  logic [7:0] i_udp_data;
  logic       i_udp_tx_en;
  logic [7:0] o_tx_data;
  logic       o_tx_en;
  logic [1:0] o_grant;
  logic       o_busy;
  logic [2:0] o_pending;
  logic [7:0] o_timeout_cnt;

  modport master (
    input  i_arp_resp_req, i_arp_req_req, i_udp_req,
    input  i_arp_ready, i_arp_data, i_arp_tx_en,
    input  i_udp_ready, i_udp_data, i_udp_tx_en,
    output o_arp_oper, o_arp_enable, o_udp_enable,
    output o_tx_data, o_tx_en, o_grant, o_busy, o_pending, o_timeout_cnt
  );

  modport slave (
    output i_arp_resp_req, i_arp_req_req, i_udp_req,
    output i_arp_ready, i_arp_data, i_arp_tx_en,
    output i_udp_ready, i_udp_data, i_udp_tx_en,
    input  o_arp_oper, o_arp_enable, o_udp_enable,
    input  o_tx_data, o_tx_en, o_grant, o_busy, o_pending, o_timeout_cnt
  );
endinterface

// File: rtl/eth_tx_sched.sv
// Ethernet TX scheduler: arbitrates ARP response / ARP request / UDP onto one
// GMII-style byte stream with engine handshaking, inter-frame gap and watchdog.
module eth_tx_sched #(
  parameter int unsigned IFG_CYCLES     = 12,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned MAX_ARP_BURST  = 4
) (
  input logic            clk,
  input logic            rst_n,
  eth_tx_sched_if.master bus
);

  localparam int unsigned GapW   = $clog2(IFG_CYCLES) + 1;
  localparam int unsigned WdW    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned BurstW = $clog2(MAX_ARP_BURST) + 1;

  localparam logic [1:0] GntNone = 2'd0;
  localparam logic [1:0] GntResp = 2'd1;
  localparam logic [1:0] GntReq  = 2'd2;
  localparam logic [1:0] GntUdp  = 2'd3;

  typedef enum logic [1:0] {StIdle, StStart, StSend, StGap} state_e;

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [2:0]        pend_q, pend_d;
  logic [2:0]        clr;
  logic [BurstW-1:0] burst_q, burst_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [WdW-1:0]    wd_q, wd_d;
  logic [7:0]        tmo_q, tmo_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_en_q, tx_en_d;

  logic       arp_sel, active, eng_ready, wd_expired;
  logic       resp_ok, req_ok, udp_ok, burst_full;
  logic [1:0] pick;

  assign arp_sel    = (grant_q == GntResp) || (grant_q == GntReq);
  assign active     = (state_q == StStart) || (state_q == StSend);
  assign eng_ready  = arp_sel ? bus.i_arp_ready : bus.i_udp_ready;
  assign wd_expired = (wd_q == WdW'(TIMEOUT_CYCLES - 1));

  // Only sources whose engine is ready compete; UDP jumps the queue once the
  // ARP burst allowance is used up.
  assign resp_ok    = pend_q[0] & bus.i_arp_ready;
  assign req_ok     = pend_q[1] & bus.i_arp_ready;
  assign udp_ok     = pend_q[2] & bus.i_udp_ready;
  assign burst_full = (burst_q == BurstW'(MAX_ARP_BURST));

  always_comb begin
    pick = GntNone;
    if (udp_ok && burst_full) pick = GntUdp;
    else if (resp_ok)         pick = GntResp;
    else if (req_ok)          pick = GntReq;
    else if (udp_ok)          pick = GntUdp;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gap_d   = gap_q;
    wd_d    = wd_q;
    tmo_d   = tmo_q;
    clr     = 3'b000;
    case (state_q)
      StIdle: begin
        if (pick != GntNone) begin
          state_d = StStart;
          grant_d = pick;
          wd_d    = '0;
          case (pick)
            GntResp: clr = 3'b001;
            GntReq:  clr = 3'b010;
            default: clr = 3'b100;
          endcase
        end
      end
      StStart, StSend: begin
        if (wd_expired) begin
          state_d = StGap;
          grant_d = GntNone;
          gap_d   = '0;
          if (tmo_q != 8'hff) tmo_d = tmo_q + 8'd1;
        end else begin
          wd_d = wd_q + WdW'(1);
          if (state_q == StStart && !eng_ready) begin
            state_d = StSend;
          end else if (state_q == StSend && eng_ready) begin
            state_d = StGap;
            grant_d = GntNone;
            gap_d   = '0;
          end
        end
      end
      default: begin
        if (gap_q == GapW'(IFG_CYCLES - 1)) state_d = StIdle;
        else                                gap_d   = gap_q + GapW'(1);
      end
    endcase
  end

  // A request pulse coinciding with its own grant keeps the flag set.
  assign pend_d = (pend_q & ~clr) | {bus.i_udp_req, bus.i_arp_req_req, bus.i_arp_resp_req};

  always_comb begin
    burst_d = burst_q;
    if (!pend_q[2]) begin
      burst_d = '0;
    end else if (state_q == StIdle && pick == GntUdp) begin
      burst_d = '0;
    end else if (state_q == StIdle && (pick == GntResp || pick == GntReq) && !burst_full) begin
      burst_d = burst_q + BurstW'(1);
    end
  end

  always_comb begin
    tx_data_d = 8'h00;
    tx_en_d   = 1'b0;
    if (active && arp_sel) begin
      tx_data_d = bus.i_arp_data;
      tx_en_d   = bus.i_arp_tx_en;
    end else if (active && grant_q == GntUdp) begin
      tx_data_d = bus.i_udp_data;
      tx_en_d   = bus.i_udp_tx_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      grant_q   <= GntNone;
      pend_q    <= 3'b000;
      burst_q   <= '0;
      gap_q     <= '0;
      wd_q      <= '0;
      tmo_q     <= 8'h00;
      tx_data_q <= 8'h00;
      tx_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      pend_q    <= pend_d;
      burst_q   <= burst_d;
      gap_q     <= gap_d;
      wd_q      <= wd_d;
      tmo_q     <= tmo_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
    end
  end

  always_comb begin
    bus.o_arp_oper = 2'd0;
    if (active && grant_q == GntResp) bus.o_arp_oper = 2'd2;
    if (active && grant_q == GntReq)  bus.o_arp_oper = 2'd1;
  end

  assign bus.o_arp_enable  = (state_q == StStart) && arp_sel;
  assign bus.o_udp_enable  = (state_q == StStart) && (grant_q == GntUdp);
  assign bus.o_tx_data     = tx_data_q;
  assign bus.o_tx_en       = tx_en_q;
  assign bus.o_grant       = grant_q;
  assign bus.o_busy        = (state_q != StIdle);
  assign bus.o_pending     = pend_q;
  assign bus.o_timeout_cnt = tmo_q;

endmodule

// File: doc/eth_tx_sched.md
Name: eth_tx_sched

Overview:
Transmit-side scheduler for the Ethernet TX path. It owns the single GMII-style TX byte stream and shares it between the ARP sender engine and the UDP sender engine. Three request sources are arbitrated: ARP response, ARP request (initial or periodic) and UDP frame. The block sequences each engine through its enable/ready handshake, inserts an inter-frame gap, guards against hung engines with a watchdog, and registers the muxed TX byte stream out.

Parameters:
IFG_CYCLES, 12, idle cycles forced between frames (min 1)
TIMEOUT_CYCLES, 4096, max cycles in START+SEND before a grant is aborted
MAX_ARP_BURST, 4, consecutive ARP grants allowed while UDP is pending before UDP is forced

Ports:
clk  in  1  TX clock (eth_tx_clk domain)
rst_n  in  1  reset, asynchronous, active-low
i_arp_resp_req  in  1  single-cycle pulse: ARP response wanted (already synchronised to clk)
i_arp_req_req  in  1  single-cycle pulse: ARP request wanted
i_udp_req  in  1  single-cycle pulse: UDP frame wanted
o_arp_oper  out  2  to ARP engine: 1 = request, 2 = response, 0 = idle
o_arp_enable  out  1  ARP engine start
i_arp_ready  in  1  ARP engine ready (drops when frame accepted, rises at end)
i_arp_data  in  8  ARP engine TX byte
i_arp_tx_en  in  1  ARP engine TX enable
o_udp_enable  out  1  UDP engine start
i_udp_ready  in  1  UDP engine ready, same handshake as ARP
i_udp_data  in  8  UDP engine TX byte
i_udp_tx_en  in  1  UDP engine TX enable
o_tx_data  out  8  TX byte to PHY
o_tx_en  out  1  TX enable to PHY
o_grant  out  2  0 none, 1 ARP resp, 2 ARP req, 3 UDP
o_busy  out  1  state != IDLE
o_pending  out  3  {udp, arp_req, arp_resp} pending flags
o_timeout_cnt  out  8  saturating count of watchdog aborts

Behaviour:
- Reset: all outputs 0, state IDLE, pending flags 0, burst counter 0, gap/watchdog counters 0. Reset mid-frame drops o_tx_en to 0 asynchronously.
- Pending flags: set by the matching request pulse, cleared on the cycle the source is granted (IDLE->START). A pulse arriving in the same cycle as its grant leaves the flag set (set wins). Repeated pulses while pending collapse into one.
- Arbitration in IDLE when any flag is set: priority ARP resp > ARP req > UDP. Exception: if UDP is pending and burst_cnt == MAX_ARP_BURST, UDP wins. burst_cnt increments on each ARP grant while UDP is pending (saturating at MAX_ARP_BURST) and clears on any UDP grant, or when UDP is not pending.
- States:
  IDLE -> START on grant (o_grant set, watchdog cleared).
  START: assert the selected engine's enable (o_arp_oper driven for ARP grants); -> SEND when that engine's ready == 0.
  SEND: enable deasserted, o_arp_oper held; -> GAP when ready == 1.
  GAP: count IFG_CYCLES cycles; o_grant = 0, o_arp_oper = 0; -> IDLE.
- Engine ready at IDLE: a grant is issued only if the target engine's ready == 1. Otherwise the next-priority pending source whose engine is ready is granted.
- Watchdog: counts every cycle in START and SEND. On reaching TIMEOUT_CYCLES, go to GAP, deassert enable and increment o_timeout_cnt (saturate at 255). The aborted source's pending flag is not restored.
- Datapath: o_tx_data/o_tx_en are the selected engine's data/tx_en, registered with 1-cycle latency. Capture occurs only in START/SEND with the matching grant; otherwise both are 0. The non-granted engine's stream is ignored entirely.
- Widths: gap and watchdog counters are sized by $clog2 of their parameter + 1; no wrap. They stop at terminal value.

Test Plan:
- Single UDP pulse, IFG_CYCLES=12, engine holds ready low 80 cycles: o_udp_enable high until ready falls. o_tx_data mirrors i_udp_data 1 cycle late for all 80 bytes. o_busy falls exactly 12 cycles after ready rises.
- arp_resp, arp_req and udp pulsed in the same cycle: grant order 1, 2, 3. o_arp_oper = 2 then 1. o_pending goes 111 -> 110 -> 100 -> 000.
- UDP pending while ARP req pulses every frame, MAX_ARP_BURST=4: exactly 4 ARP grants, then grant 3, then burst_cnt = 0.
- ARP engine never drops ready, TIMEOUT_CYCLES=4096: abort at cycle 4096 of START, o_timeout_cnt = 1, IFG enforced, next pending UDP granted.
- arp_resp pulse on the same cycle as its own grant: flag remains 1 and a second ARP response frame follows after the gap.
- rst_n asserted mid-SEND at byte 20: o_tx_en = 0 immediately, o_pending = 0. After release, no enable is issued until a new pulse arrives.
